// File: rtl/fault_test_sequencer.sv
// Clocked stuck-at test applicator: stores test vectors, drives them onto a true and a
// faulty circuit, and counts/locates the vectors whose two responses disagree.
module fault_test_sequencer #(
    parameter int VEC_W  = 3,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [VEC_W-1:0] load_data,
    output logic             load_ready,
    input  logic             clear,
    input  logic             start,
    output logic [VEC_W-1:0] vec_out,
    input  logic             true_in,
    input  logic             fault_in,
    output logic             busy,
    output logic             done,
    output logic             detected,
    output logic [CNT_W-1:0] detect_count,
    output logic [IDX_W-1:0] first_idx,
    output logic [CNT_W-1:0] vec_count
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] detect_count_q, detect_count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [VEC_W-1:0] vec_out_q, vec_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             detected_q, detected_d;

    logic load_ready_s;
    logic load_fire_s;
    logic last_s;
    logic mismatch_s;

    assign load_ready_s = (state_q == S_IDLE) && (vec_count_q < CNT_W'(DEPTH)) && !start && !clear;
    assign load_fire_s  = load_valid && load_ready_s;
    assign last_s       = ((CNT_W'(idx_q) + CNT_W'(1)) == vec_count_q);
    assign mismatch_s   = true_in ^ fault_in;

    // Next-state and result computation for the run controller.
    always_comb begin
        state_d        = state_q;
        vec_count_d    = vec_count_q;
        detect_count_d = detect_count_q;
        idx_d          = idx_q;
        first_idx_d    = first_idx_q;
        settle_d       = settle_q;
        vec_out_d      = vec_out_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        detected_d     = detected_q;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    vec_count_d = '0;
                end else if (start) begin
                    detected_d     = 1'b0;
                    detect_count_d = '0;
                    first_idx_d    = '0;
                    if (vec_count_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d     = '0;
                        vec_out_d = mem_q[0];
                        settle_d  = SET_W'(SETTLE - 1);
                        busy_d    = 1'b1;
                        state_d   = S_RUN;
                    end
                end else if (load_fire_s) begin
                    vec_count_d = vec_count_q + CNT_W'(1);
                end else begin
                    vec_count_d = vec_count_q;
                end
            end
            S_RUN: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SET_W'(1);
                end else begin
                    // Final settle edge: the response of the held vector is valid now.
                    if (mismatch_s) begin
                        detect_count_d = detect_count_q + CNT_W'(1);
                        if (!detected_q) begin
                            first_idx_d = idx_q;
                            detected_d  = 1'b1;
                        end else begin
                            first_idx_d = first_idx_q;
                        end
                    end else begin
                        detect_count_d = detect_count_q;
                    end
                    if (!last_s) begin
                        idx_d     = idx_q + IDX_W'(1);
                        vec_out_d = mem_q[idx_q + IDX_W'(1)];
                        settle_d  = SET_W'(SETTLE - 1);
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            vec_count_q    <= '0;
            detect_count_q <= '0;
            idx_q          <= '0;
            first_idx_q    <= '0;
            settle_q       <= '0;
            vec_out_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            detected_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_count_q    <= vec_count_d;
            detect_count_q <= detect_count_d;
            idx_q          <= idx_d;
            first_idx_q    <= first_idx_d;
            settle_q       <= settle_d;
            vec_out_q      <= vec_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            detected_q     <= detected_d;
        end
    end

    // Vector storage; contents beyond vec_count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            mem_q[vec_count_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign load_ready   = load_ready_s;
    assign vec_out      = vec_out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign detected     = detected_q;
    assign detect_count = detect_count_q;
    assign first_idx    = first_idx_q;
    assign vec_count    = vec_count_q;

endmodule
